// File: rtl/elevator_dispatch_if.sv
// Request/status bundle between the request front end, the dispatcher and
// the car drive/display logic.
//   master : drives the request vectors, door_hold and fault; observes status
//   slave  : the dispatcher; consumes requests, drives floor/motor/door/lamps
// Parameters: floor (number of floors), FW (floor index width).
interface elevator_dispatch_if #(
   parameter int unsigned floor = 4,
   parameter int unsigned FW    = 2
);
   logic [floor-1:0] queueUp;
   logic [floor-1:0] queueDown;
   logic [floor-1:0] queueinside;
   logic             door_hold;
   logic             fault;
   logic [FW-1:0]    cur_floor;
   logic             moving;
   logic             dir_up;
   logic             dir_down;
   logic             door_open;
   logic [floor-1:0] pendUp;
   logic [floor-1:0] pendDown;
   logic [floor-1:0] pendInside;
   logic             alarm;

   modport master (
      output queueUp, queueDown, queueinside, door_hold, fault,
      input  cur_floor, moving, dir_up, dir_down, door_open,
             pendUp, pendDown, pendInside, alarm
   );

   modport slave (
      input  queueUp, queueDown, queueinside, door_hold, fault,
      output cur_floor, moving, dir_up, dir_down, door_open,
             pendUp, pendDown, pendInside, alarm
   );
endinterface

// File: rtl/elevator_dispatch.sv
// Collective up/down elevator dispatcher.
// Latches hall/car requests into lamp registers, moves the car one floor per
// MOVE_CYCLES, opens the door for DOOR_CYCLES on a served floor, supports
// door hold and a fault/alarm state.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : elevator_dispatch_if.slave
//          in : queueUp, queueDown, queueinside, door_hold, fault
//          out: cur_floor, moving, dir_up, dir_down, door_open,
//               pendUp, pendDown, pendInside, alarm
module elevator_dispatch #(
   parameter int unsigned floor       = 4,
   parameter int unsigned FW          = 2,
   parameter int unsigned MOVE_CYCLES = 200,
   parameter int unsigned DOOR_CYCLES = 400
) (
   input logic               clk,
   input logic               rst,
   elevator_dispatch_if.slave bus
);

   localparam int unsigned CMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0]    MOVE_LAST = CW'(MOVE_CYCLES - 1);
   localparam logic [CW-1:0]    DOOR_LAST = CW'(DOOR_CYCLES - 1);
   localparam logic [FW-1:0]    TOP       = FW'(floor - 1);
   localparam logic [floor-1:0] ONE       = floor'(1);
   // No up call exists at the top floor, no down call at the bottom floor.
   localparam logic [floor-1:0] UP_OK     = ~(ONE << (floor - 1));
   localparam logic [floor-1:0] DN_OK     = ~ONE;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MOVE,
      ST_DOOR,
      ST_FAULT
   } state_t;

   state_t           state_q, state_n;
   logic [FW-1:0]    cur_q, cur_n;
   logic [CW-1:0]    cnt_q, cnt_n;
   logic             dir_up_q, dir_up_n;
   logic             dir_dn_q, dir_dn_n;
   logic             prev_up_q, prev_up_n;
   logic [floor-1:0] pend_up_q, pend_up_n;
   logic [floor-1:0] pend_dn_q, pend_dn_n;
   logic [floor-1:0] pend_in_q, pend_in_n;

   logic [floor-1:0] req_all;
   logic [floor-1:0] q_any;
   logic [floor-1:0] cur_mask;
   logic [floor-1:0] nf_mask;
   logic [floor-1:0] clr_up, clr_dn, clr_in;
   logic [floor-1:0] consume;
   logic [FW-1:0]    nf;
   logic             more;
   logic             hall_d;
   logic             hall_o;
   logic             go_up;

   function automatic logic [floor-1:0] above_of(input logic [FW-1:0] f);
      logic [floor-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < floor; i++) m[i] = (i > 32'(f));
      return m;
   endfunction

   function automatic logic [floor-1:0] below_of(input logic [FW-1:0] f);
      logic [floor-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < floor; i++) m[i] = (i < 32'(f));
      return m;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cur_q     <= '0;
         cnt_q     <= '0;
         dir_up_q  <= 1'b0;
         dir_dn_q  <= 1'b0;
         prev_up_q <= 1'b1;
         pend_up_q <= '0;
         pend_dn_q <= '0;
         pend_in_q <= '0;
      end else begin
         state_q   <= state_n;
         cur_q     <= cur_n;
         cnt_q     <= cnt_n;
         dir_up_q  <= dir_up_n;
         dir_dn_q  <= dir_dn_n;
         prev_up_q <= prev_up_n;
         pend_up_q <= pend_up_n;
         pend_dn_q <= pend_dn_n;
         pend_in_q <= pend_in_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      cur_n     = cur_q;
      cnt_n     = cnt_q;
      dir_up_n  = dir_up_q;
      dir_dn_n  = dir_dn_q;
      prev_up_n = prev_up_q;
      clr_up    = '0;
      clr_dn    = '0;
      clr_in    = '0;
      consume   = '0;
      go_up     = 1'b0;

      req_all  = pend_up_q | pend_dn_q | pend_in_q;
      q_any    = bus.queueUp | bus.queueDown | bus.queueinside;
      cur_mask = ONE << cur_q;

      // Floor reached at the end of the current travel step.
      nf = cur_q;
      if (dir_up_q && cur_q != TOP) begin
         nf = cur_q + 1'b1;
      end else if (dir_dn_q && cur_q != '0) begin
         nf = cur_q - 1'b1;
      end
      nf_mask = ONE << nf;
      more    = dir_up_q ? |(req_all & above_of(nf)) : |(req_all & below_of(nf));
      hall_d  = dir_up_q ? pend_up_q[nf] : pend_dn_q[nf];
      hall_o  = dir_up_q ? pend_dn_q[nf] : pend_up_q[nf];

      unique case (state_q)
         ST_IDLE: begin
            cnt_n    = '0;
            dir_up_n = 1'b0;
            dir_dn_n = 1'b0;
            if (req_all[cur_q]) begin
               // With no travel direction, every call at this floor is answered.
               state_n = ST_DOOR;
               clr_up  = cur_mask;
               clr_dn  = cur_mask;
               clr_in  = cur_mask;
            end else if (|req_all) begin
               go_up     = prev_up_q ? |(req_all & above_of(cur_q))
                                     : !(|(req_all & below_of(cur_q)));
               state_n   = ST_MOVE;
               dir_up_n  = go_up;
               dir_dn_n  = !go_up;
               prev_up_n = go_up;
            end
         end

         ST_MOVE: begin
            if (cnt_q == MOVE_LAST) begin
               cur_n = nf;
               cnt_n = '0;
               if (pend_in_q[nf] || hall_d || (!more && hall_o)) begin
                  state_n = ST_DOOR;
                  clr_in  = nf_mask;
                  if (dir_up_q) begin
                     clr_up = nf_mask;
                     if (!more) clr_dn = nf_mask;
                  end else begin
                     clr_dn = nf_mask;
                     if (!more) clr_up = nf_mask;
                  end
               end else if (!more) begin
                  state_n  = ST_IDLE;
                  dir_up_n = 1'b0;
                  dir_dn_n = 1'b0;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end

         ST_DOOR: begin
            // Calls for the open floor are answered immediately instead of lit.
            consume = cur_mask;
            if (bus.door_hold || q_any[cur_q]) begin
               cnt_n = '0;
            end else if (cnt_q == DOOR_LAST) begin
               state_n  = ST_IDLE;
               cnt_n    = '0;
               dir_up_n = 1'b0;
               dir_dn_n = 1'b0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end

         ST_FAULT: begin
            cnt_n = '0;
            if (!bus.fault) begin
               state_n  = ST_IDLE;
               dir_up_n = 1'b0;
               dir_dn_n = 1'b0;
            end
         end

         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase

      // Fault pre-empts every transition; floor and lamps freeze, capture goes on,
      // and an aborted travel step restarts from a zero count.
      if (bus.fault) begin
         state_n   = ST_FAULT;
         cur_n     = cur_q;
         cnt_n     = '0;
         dir_up_n  = dir_up_q;
         dir_dn_n  = dir_dn_q;
         prev_up_n = prev_up_q;
         clr_up    = '0;
         clr_dn    = '0;
         clr_in    = '0;
         consume   = '0;
      end

      pend_up_n = (pend_up_q | (bus.queueUp     & ~consume)) & ~clr_up & UP_OK;
      pend_dn_n = (pend_dn_q | (bus.queueDown   & ~consume)) & ~clr_dn & DN_OK;
      pend_in_n = (pend_in_q | (bus.queueinside & ~consume)) & ~clr_in;
   end

   assign bus.cur_floor  = cur_q;
   assign bus.moving     = (state_q == ST_MOVE);
   assign bus.door_open  = (state_q == ST_DOOR);
   assign bus.alarm      = (state_q == ST_FAULT);
   assign bus.dir_up     = dir_up_q;
   assign bus.dir_down   = dir_dn_q;
   assign bus.pendUp     = pend_up_q;
   assign bus.pendDown   = pend_dn_q;
   assign bus.pendInside = pend_in_q;

endmodule

// File: tb/tb_elevator_dispatch.sv
// Self-checking bench for elevator_dispatch (4 floors, 4-cycle travel,
// 6-cycle door). Expected stop floors go into a queue as requests are driven;
// a monitor pops one on every door opening and compares the car floor.
module tb_elevator_dispatch;
   localparam int unsigned NF = 4;
   localparam int unsigned FWB = 2;
   localparam int unsigned MC = 4;
   localparam int unsigned DC = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   elevator_dispatch_if #(.floor(NF), .FW(FWB)) bus ();

   elevator_dispatch #(
      .floor(NF), .FW(FWB), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec  = 0;
   int n_miss = 0;
   int exp_stops[$];
   logic door_d = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Stop scoreboard: each rising door_open must match the next expected floor.
   always @(negedge clk) begin
      int f;
      if (bus.door_open && !door_d) begin
         if (exp_stops.size() == 0) begin
            check_val("unexpected_stop", 32'(bus.cur_floor), 32'd99);
         end else begin
            f = exp_stops.pop_front();
            check_val("stop_floor", 32'(bus.cur_floor), 32'(f));
         end
      end
      door_d <= bus.door_open;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_door(input logic v, input string tag);
      for (int k = 0; k < 300 && bus.door_open !== v; k++) tick();
      check_val(tag, 32'(bus.door_open), 32'(v));
   endtask

   task automatic wait_moving(input string tag);
      for (int k = 0; k < 300 && bus.moving !== 1'b1; k++) tick();
      check_val(tag, 32'(bus.moving), 32'd1);
   endtask

   task automatic wait_floor(input int f, input string tag);
      for (int k = 0; k < 300 && 32'(bus.cur_floor) != f; k++) tick();
      check_val(tag, 32'(bus.cur_floor), 32'(f));
   endtask

   // Number of sampled cycles the car spends moving at floor f.
   task automatic measure_move(input int f, output int n);
      n = 0;
      while (bus.moving && 32'(bus.cur_floor) == f && n < 300) begin
         n++;
         tick();
      end
   endtask

   task automatic measure_door(output int n);
      n = 0;
      while (bus.door_open && n < 300) begin
         n++;
         tick();
      end
   endtask

   task automatic do_reset();
      bus.queueUp = '0; bus.queueDown = '0; bus.queueinside = '0;
      bus.door_hold = 1'b0; bus.fault = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_floor"}, 32'(bus.cur_floor), 32'd0);
      check_val({tag, "_motor"}, {28'd0, bus.moving, bus.dir_up, bus.dir_down, bus.door_open}, 32'd0);
      check_val({tag, "_alarm"}, 32'(bus.alarm), 32'd0);
      check_val({tag, "_lamps"}, {20'd0, bus.pendUp, bus.pendDown, bus.pendInside}, 32'd0);
   endtask

   initial begin
      int n;
      int busy;

      // Reset state
      do_reset();
      check_reset_state("reset");

      // 1: single car call to floor 2
      bus.queueinside = 4'b0100;
      exp_stops.push_back(2);
      tick();
      bus.queueinside = '0;
      check_val("t1_lamp", 32'(bus.pendInside), 32'h4);
      wait_moving("t1_start");
      check_val("t1_dir", {30'd0, bus.dir_up, bus.dir_down}, 32'd2);
      measure_move(0, n);
      check_val("t1_travel0", 32'(n), 32'(MC));
      measure_move(1, n);
      check_val("t1_travel1", 32'(n), 32'(MC));
      check_val("t1_at_door", {30'd0, bus.door_open, bus.moving}, 32'd2);
      check_val("t1_lamp_clr", 32'(bus.pendInside), 32'd0);
      measure_door(n);
      check_val("t1_door_len", 32'(n), 32'(DC));

      // 2: collective up sweep with hall calls, then reversal
      do_reset();
      bus.queueinside = 4'b1000;
      exp_stops.push_back(1);
      exp_stops.push_back(3);
      exp_stops.push_back(2);
      tick();
      bus.queueinside = '0;
      wait_moving("t2_start");
      bus.queueUp = 4'b0010;
      bus.queueDown = 4'b0100;
      tick();
      bus.queueUp = '0;
      bus.queueDown = '0;
      check_val("t2_up_lamp", 32'(bus.pendUp), 32'h2);
      check_val("t2_dn_lamp", 32'(bus.pendDown), 32'h4);
      wait_door(1'b1, "t2_door1");
      check_val("t2_up_clr", 32'(bus.pendUp), 32'd0);
      check_val("t2_dn_kept", 32'(bus.pendDown), 32'h4);
      wait_door(1'b0, "t2_close1");
      wait_door(1'b1, "t2_door3");
      check_val("t2_floor3", 32'(bus.cur_floor), 32'd3);
      wait_door(1'b0, "t2_close3");
      wait_moving("t2_reverse");
      check_val("t2_dir_dn", {30'd0, bus.dir_up, bus.dir_down}, 32'd1);
      wait_door(1'b1, "t2_door2");
      check_val("t2_dn_clr", 32'(bus.pendDown), 32'd0);
      wait_door(1'b0, "t2_close2");

      // 3: door hold and same-floor call during door
      bus.queueinside = 4'b0100;
      exp_stops.push_back(2);
      tick();
      bus.queueinside = '0;
      wait_door(1'b1, "t3_open_a");
      n = 1;
      bus.door_hold = 1'b1;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (k == 9) bus.door_hold = 1'b0;
         if (!bus.door_open) break;
         n++;
      end
      check_val("t3_hold_len", 32'(n), 32'(10 + DC));
      bus.queueinside = 4'b0100;
      exp_stops.push_back(2);
      tick();
      bus.queueinside = '0;
      wait_door(1'b1, "t3_open_b");
      n = 1;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (k == 2) check_val("t3_consumed", 32'(bus.pendInside), 32'd0);
         if (k == 1) bus.queueinside = 4'b0100;
         if (k == 2) bus.queueinside = '0;
         if (!bus.door_open) break;
         n++;
      end
      check_val("t3_reload_len", 32'(n), 32'(3 + DC));

      // 4: fault between floors 1 and 2
      do_reset();
      bus.queueinside = 4'b1000;
      exp_stops.push_back(3);
      tick();
      bus.queueinside = '0;
      wait_floor(1, "t4_reach1");
      tick();
      tick();
      bus.fault = 1'b1;
      tick();
      check_val("t4_fault", {29'd0, bus.moving, bus.door_open, bus.alarm}, 32'd1);
      check_val("t4_fault_floor", 32'(bus.cur_floor), 32'd1);
      repeat (3) tick();
      check_val("t4_fault_hold", {29'd0, bus.cur_floor, bus.alarm}, 32'd3);
      check_val("t4_lamp_hold", 32'(bus.pendInside), 32'h8);
      bus.fault = 1'b0;
      wait_moving("t4_resume");
      check_val("t4_alarm_off", 32'(bus.alarm), 32'd0);
      measure_move(1, n);
      check_val("t4_full_step", 32'(n), 32'(MC));
      check_val("t4_floor2", 32'(bus.cur_floor), 32'd2);

      // 5: reset during door at floor 3 with lamps lit
      wait_door(1'b1, "t5_door3");
      bus.queueUp = 4'b0010;
      bus.queueinside = 4'b0001;
      tick();
      bus.queueUp = '0;
      bus.queueinside = '0;
      check_val("t5_lamps", {24'd0, bus.pendUp, bus.pendInside}, 32'h21);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("t5_rst");

      // 6: impossible hall calls are dropped
      bus.queueUp = 4'b1000;
      bus.queueDown = 4'b0001;
      tick();
      bus.queueUp = '0;
      bus.queueDown = '0;
      check_val("t6_lamps", {24'd0, bus.pendUp, bus.pendDown}, 32'd0);
      busy = 0;
      repeat (10) begin
         tick();
         if (bus.moving || bus.door_open || bus.dir_up || bus.dir_down) busy++;
      end
      check_val("t6_idle", 32'(busy), 32'd0);

      check_val("stops_left", 32'(exp_stops.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
